// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared encodings for the hazard controller
package hazard_ctrl_pkg;
    typedef enum logic [1:0] {
        FWD_REG  = 2'b00,
        FWD_RESW = 2'b01,
        FWD_ALUM = 2'b10
    } fwd_e;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        ERR  = 2'b10
    } state_e;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side signal bundle of the hazard controller
interface hazard_ctrl_if import hazard_ctrl_pkg::*; #(
    parameter int RA_W  = 4,
    parameter int CNT_W = 16
) ();
    logic [RA_W-1:0]  ra1e, ra2e, ra1d, ra2d, wa3e, wa3m, wa3w;
    logic             reg_write_m, reg_write_w, mem_to_reg_e;
    logic             pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w, branch_taken_e;
    logic             mem_access_m, mem_ready, clr_cnt;
    fwd_e             forward_ae, forward_be;
    logic             stall_f, stall_d, stall_e, stall_m;
    logic             flush_d, flush_e, flush_w, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    modport master (
        output ra1e, ra2e, ra1d, ra2d, wa3e, wa3m, wa3w,
               reg_write_m, reg_write_w, mem_to_reg_e,
               pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w, branch_taken_e,
               mem_access_m, mem_ready, clr_cnt,
        input  forward_ae, forward_be, stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_w, mem_err, stall_cnt, flush_cnt
    );
    modport slave (
        input  ra1e, ra2e, ra1d, ra2d, wa3e, wa3m, wa3w,
               reg_write_m, reg_write_w, mem_to_reg_e,
               pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w, branch_taken_e,
               mem_access_m, mem_ready, clr_cnt,
        output forward_ae, forward_be, stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_w, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: saturating event counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);
    // clear wins over increment; count sticks at all-ones
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, stall/flush generation and memory-wait timeout
module hazard_ctrl import hazard_ctrl_pkg::*; #(
    parameter int RA_W    = 4,
    parameter int PC_REG  = 15,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave hz
);
    localparam int WC_W = $clog2(TIMEOUT + 1);
    localparam logic [RA_W-1:0] PC = RA_W'(PC_REG);
    state_e          state;
    logic [WC_W-1:0] wait_cnt;
    logic            ldr_stall, pc_pend, mem_stall;
    assign hz.forward_ae = (hz.reg_write_m && hz.wa3m == hz.ra1e && hz.ra1e != PC) ? FWD_ALUM :
                           (hz.reg_write_w && hz.wa3w == hz.ra1e && hz.ra1e != PC) ? FWD_RESW : FWD_REG;
    assign hz.forward_be = (hz.reg_write_m && hz.wa3m == hz.ra2e && hz.ra2e != PC) ? FWD_ALUM :
                           (hz.reg_write_w && hz.wa3w == hz.ra2e && hz.ra2e != PC) ? FWD_RESW : FWD_REG;
    assign ldr_stall = hz.mem_to_reg_e && (hz.wa3e == hz.ra1d || hz.wa3e == hz.ra2d);
    assign pc_pend   = hz.pcsrc_d || hz.pcsrc_e || hz.pcsrc_m;
    assign mem_stall = (hz.mem_access_m && !hz.mem_ready) || state == ERR;
    // memory stall freezes everything; a taken branch beats a load-use stall
    always_comb begin
        hz.stall_f = mem_stall ? 1'b1 : hz.branch_taken_e ? 1'b0 : ldr_stall || pc_pend;
        hz.stall_d = mem_stall ? 1'b1 : hz.branch_taken_e ? 1'b0 : ldr_stall;
        hz.flush_d = mem_stall ? 1'b0 : hz.branch_taken_e ? 1'b1 : pc_pend || hz.pcsrc_w;
        hz.flush_e = mem_stall ? 1'b0 : hz.branch_taken_e ? 1'b1 : ldr_stall;
        hz.stall_e = mem_stall;
        hz.stall_m = mem_stall;
        hz.flush_w = mem_stall;
    end
    // memory-wait tracker: a completion on the timeout edge still returns to IDLE
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            hz.mem_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (hz.mem_access_m && !hz.mem_ready) state <= WAIT;
                end
                WAIT: begin
                    if (hz.mem_ready) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
                        state      <= ERR;
                        hz.mem_err <= 1'b1;
                    end else wait_cnt <= wait_cnt + 1'b1;
                end
                default: begin
                    state      <= ERR;
                    hz.mem_err <= 1'b1;
                end
            endcase
        end
    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk(clk), .reset(reset), .clr(hz.clr_cnt), .inc(hz.stall_f), .cnt(hz.stall_cnt)
    );
    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk(clk), .reset(reset), .clr(hz.clr_cnt), .inc(hz.flush_e), .cnt(hz.flush_cnt)
    );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0, passed = 0, failed = 0;
    always #5 clk = ~clk;
    hazard_ctrl_if #(.RA_W(4), .CNT_W(16)) ifa ();
    hazard_ctrl_if #(.RA_W(4), .CNT_W(2))  ifb ();
    hazard_ctrl #(.RA_W(4), .PC_REG(15), .CNT_W(16), .TIMEOUT(64)) dut_a (.clk(clk), .reset(reset), .hz(ifa));
    hazard_ctrl #(.RA_W(4), .PC_REG(15), .CNT_W(2), .TIMEOUT(4)) dut_b (.clk(clk), .reset(reset), .hz(ifb));
    always_comb begin
        ifb.ra1e = ifa.ra1e; ifb.ra2e = ifa.ra2e; ifb.ra1d = ifa.ra1d; ifb.ra2d = ifa.ra2d;
        ifb.wa3e = ifa.wa3e; ifb.wa3m = ifa.wa3m; ifb.wa3w = ifa.wa3w;
        ifb.reg_write_m = ifa.reg_write_m; ifb.reg_write_w = ifa.reg_write_w;
        ifb.mem_to_reg_e = ifa.mem_to_reg_e; ifb.branch_taken_e = ifa.branch_taken_e;
        ifb.pcsrc_d = ifa.pcsrc_d; ifb.pcsrc_e = ifa.pcsrc_e;
        ifb.pcsrc_m = ifa.pcsrc_m; ifb.pcsrc_w = ifa.pcsrc_w;
        ifb.mem_access_m = ifa.mem_access_m; ifb.mem_ready = ifa.mem_ready; ifb.clr_cnt = ifa.clr_cnt;
    end
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic idle();
        {ifa.ra1e, ifa.ra2e, ifa.ra1d, ifa.ra2d, ifa.wa3e, ifa.wa3m, ifa.wa3w} = '0;
        {ifa.reg_write_m, ifa.reg_write_w, ifa.mem_to_reg_e, ifa.branch_taken_e} = '0;
        {ifa.pcsrc_d, ifa.pcsrc_e, ifa.pcsrc_m, ifa.pcsrc_w} = '0;
        {ifa.mem_access_m, ifa.clr_cnt} = '0;
        ifa.mem_ready = 1'b1;
    endtask
    task automatic step();
        @(negedge clk);
    endtask
    task automatic clear_counters();
        ifa.clr_cnt = 1'b1;
        step();
        ifa.clr_cnt = 1'b0;
    endtask
    function automatic logic [1:0] mfwd(logic [3:0] ra, logic rwm, logic [3:0] wm, logic rww, logic [3:0] ww);
        if (ra == 4'd15) return 2'b00;
        if (rwm && wm == ra) return 2'b10;
        if (rww && ww == ra) return 2'b01;
        return 2'b00;
    endfunction
    function automatic logic [3:0] rnd_ra();
        return ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    endfunction
    int       m_wait, m_sc, m_fc;
    bit       m_err;
    logic     ldr, pcp, ms, sf, sd, se, sm, fd, fe, fw;
    logic [1:0] fa, fb;
    initial begin
        idle();
        #1;
        check("reset_mem_err", ifa.mem_err, 0);
        check("reset_stall_cnt", ifa.stall_cnt, 0);
        check("reset_flush_cnt", ifa.flush_cnt, 0);
        check("reset_fwd_a", ifa.forward_ae, 0);
        check("reset_stall_f", ifa.stall_f, 0);
        step();
        reset = 1'b1;
        step();
        ifa.reg_write_m = 1; ifa.wa3m = 3; ifa.reg_write_w = 1; ifa.wa3w = 3; ifa.ra1e = 3; ifa.ra2e = 3;
        #1;
        check("fwd_m", ifa.forward_ae, 2'b10);
        check("fwd_m_b", ifa.forward_be, 2'b10);
        ifa.reg_write_m = 0;
        #1;
        check("fwd_w", ifa.forward_ae, 2'b01);
        ifa.reg_write_m = 1; ifa.ra1e = 15; ifa.wa3m = 15;
        #1;
        check("fwd_pc", ifa.forward_ae, 2'b00);
        check("fwd_w_b", ifa.forward_be, 2'b01);
        idle();
        ifa.mem_to_reg_e = 1; ifa.wa3e = 5; ifa.ra2d = 5; ifa.ra1d = 2;
        #1;
        check("ldr_stall", {ifa.stall_f, ifa.stall_d, ifa.flush_e, ifa.flush_d}, 4'b1110);
        ifa.branch_taken_e = 1;
        #1;
        check("ldr_branch", {ifa.stall_f, ifa.stall_d, ifa.flush_d, ifa.flush_e}, 4'b0011);
        idle();
        clear_counters();
        for (int k = 0; k < 4; k++) begin
            {ifa.pcsrc_d, ifa.pcsrc_e, ifa.pcsrc_m, ifa.pcsrc_w} = 4'b1000 >> k;
            #1;
            check("pc_stall_f", ifa.stall_f, k < 3);
            check("pc_flush_d", ifa.flush_d, 1);
            step();
        end
        idle();
        #1;
        check("pc_stall_cnt", ifa.stall_cnt, 3);
        check("pc_flush_cnt", ifa.flush_cnt, 0);
        clear_counters();
        ifa.mem_access_m = 1; ifa.mem_ready = 0; ifa.branch_taken_e = 1; ifa.pcsrc_d = 1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("mw_stalls", {ifa.stall_f, ifa.stall_d, ifa.stall_e, ifa.stall_m, ifa.flush_w,
                                ifa.flush_d, ifa.flush_e}, 7'b1111100);
            check("mw_state", dut_a.state, (k == 0) ? IDLE : WAIT);
            step();
        end
        ifa.mem_ready = 1; ifa.branch_taken_e = 0;
        #1;
        check("mw_release", {ifa.stall_e, ifa.flush_w, ifa.flush_d}, 3'b001);
        step();
        idle();
        #1;
        check("mw_idle", dut_a.state, IDLE);
        check("mw_err", ifa.mem_err, 0);
        check("mw_stall_cnt", ifa.stall_cnt, 6);
        ifa.mem_access_m = 1; ifa.mem_ready = 0;
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_wait_state", dut_a.state, IDLE);
        check("rst_wait_stall", ifa.stall_e, 1);
        step();
        reset = 1'b1;
        ifa.mem_ready = 1;
        step();
        #1;
        check("rst_wait_resume", dut_a.state, IDLE);
        idle();
        ifa.mem_access_m = 1; ifa.mem_ready = 0;
        for (int k = 1; k <= 7; k++) begin
            step();
            #1;
            check("to_err", ifb.mem_err, k >= 5);
        end
        ifa.mem_access_m = 0; ifa.mem_ready = 1;
        #1;
        check("to_err_stall", {ifb.stall_f, ifb.flush_w}, 2'b11);
        step();
        #1;
        check("to_err_sticky", ifb.mem_err, 1);
        reset = 1'b0;
        #1;
        check("to_err_reset", {ifb.mem_err, ifb.stall_f}, 2'b00);
        step();
        reset = 1'b1;
        ifa.mem_access_m = 1; ifa.mem_ready = 0;
        for (int k = 0; k < 4; k++) step();
        ifa.mem_ready = 1;
        step();
        #1;
        check("to_edge_err", ifb.mem_err, 0);
        check("to_edge_state", dut_b.state, IDLE);
        idle();
        clear_counters();
        ifa.pcsrc_d = 1;
        for (int k = 1; k <= 6; k++) begin
            step();
            #1;
            if (k == 2 || k == 6) check("sat_cnt", ifb.stall_cnt, (k == 2) ? 2 : 3);
        end
        ifa.clr_cnt = 1;
        step();
        ifa.clr_cnt = 0;
        #1;
        check("sat_clr", ifb.stall_cnt, 0);
        idle();
        reset = 1'b0;
        step();
        reset = 1'b1;
        m_wait = -1; m_err = 0; m_sc = 0; m_fc = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            ifa.ra1e = rnd_ra(); ifa.ra2e = rnd_ra(); ifa.ra1d = rnd_ra(); ifa.ra2d = rnd_ra();
            ifa.wa3e = rnd_ra(); ifa.wa3m = rnd_ra(); ifa.wa3w = rnd_ra();
            ifa.reg_write_m = 1'($urandom); ifa.reg_write_w = 1'($urandom);
            ifa.mem_to_reg_e = ($urandom_range(0, 2) == 0);
            ifa.branch_taken_e = ($urandom_range(0, 5) == 0);
            ifa.pcsrc_d = ($urandom_range(0, 6) == 0); ifa.pcsrc_e = ($urandom_range(0, 6) == 0);
            ifa.pcsrc_m = ($urandom_range(0, 6) == 0); ifa.pcsrc_w = ($urandom_range(0, 6) == 0);
            ifa.mem_access_m = ($urandom_range(0, 3) == 0);
            ifa.mem_ready = ($urandom_range(0, 3) != 0);
            ifa.clr_cnt = ($urandom_range(0, 40) == 0);
            #1;
            fa = mfwd(ifa.ra1e, ifa.reg_write_m, ifa.wa3m, ifa.reg_write_w, ifa.wa3w);
            fb = mfwd(ifa.ra2e, ifa.reg_write_m, ifa.wa3m, ifa.reg_write_w, ifa.wa3w);
            ldr = ifa.mem_to_reg_e && (ifa.wa3e == ifa.ra1d || ifa.wa3e == ifa.ra2d);
            pcp = ifa.pcsrc_d || ifa.pcsrc_e || ifa.pcsrc_m;
            ms = (ifa.mem_access_m && !ifa.mem_ready) || m_err;
            if (ms) {sf, sd, se, sm, fd, fe, fw} = 7'b1111001;
            else if (ifa.branch_taken_e) {sf, sd, se, sm, fd, fe, fw} = 7'b0000110;
            else {sf, sd, se, sm, fd, fe, fw} = {ldr || pcp, ldr, 2'b00, pcp || ifa.pcsrc_w, ldr, 1'b0};
            check("rnd_outputs",
                  {ifa.forward_ae, ifa.forward_be, ifa.stall_f, ifa.stall_d, ifa.stall_e, ifa.stall_m,
                   ifa.flush_d, ifa.flush_e, ifa.flush_w, ifa.mem_err},
                  {fa, fb, sf, sd, se, sm, fd, fe, fw, m_err});
            check("rnd_stall_cnt", ifa.stall_cnt, m_sc);
            check("rnd_flush_cnt", ifa.flush_cnt, m_fc);
            m_sc = ifa.clr_cnt ? 0 : (sf && m_sc < 65535) ? m_sc + 1 : m_sc;
            m_fc = ifa.clr_cnt ? 0 : (fe && m_fc < 65535) ? m_fc + 1 : m_fc;
            if (!m_err) begin
                if (m_wait < 0) m_wait = (ifa.mem_access_m && !ifa.mem_ready) ? 0 : -1;
                else if (ifa.mem_ready) m_wait = -1;
                else if (m_wait + 1 >= 64) m_err = 1;
                else m_wait = m_wait + 1;
            end
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL take parameters: RA_W, default 4, register address width; PC_REG, default 15, PC register index that is never forwarded; CNT_W, default 16, event counter width; TIMEOUT, default 64, memory-wait cycles before error.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
- ra1e, ra2e  in  RA_W  Execute-stage source registers.
- ra1d, ra2d  in  RA_W  Decode-stage source registers.
- wa3e, wa3m, wa3w  in  RA_W  destination registers in E, M and W.
- reg_write_m, reg_write_w  in  1  register write enables in M and W.
- mem_to_reg_e  in  1  load in Execute.
- pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w  in  1  PC-write instruction in that stage.
- branch_taken_e  in  1  branch resolved taken.
- mem_access_m, mem_ready  in  1  data-memory request in M; memory done.
- clr_cnt  in  1  synchronous counter clear.
- forward_ae, forward_be  out  2  00 register file, 01 ResultW, 10 ALUOutM.
- stall_f, stall_d, stall_e, stall_m  out  1  hold the stage register.
- flush_d, flush_e, flush_w  out  1  load a bubble.
- mem_err  out  1  sticky timeout flag.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

Function
REQ-003 forward_ae SHALL be 10 when reg_write_m and wa3m==ra1e and ra1e!=PC_REG; otherwise 01 when reg_write_w and wa3w==ra1e and ra1e!=PC_REG; otherwise 00. M has priority over W. forward_be SHALL follow the same rule using ra2e.
REQ-004 ldr_stall SHALL be mem_to_reg_e and (wa3e==ra1d or wa3e==ra2d).
REQ-005 pc_pend SHALL be pcsrc_d or pcsrc_e or pcsrc_m.
REQ-006 mem_stall SHALL be (mem_access_m and not mem_ready), or state==ERR.
REQ-007 When mem_stall is high: stall_f, stall_d, stall_e and stall_m SHALL all be 1; flush_w SHALL be 1; flush_d and flush_e SHALL be 0. This overrides REQ-008 to REQ-010.
REQ-008 Otherwise, with branch_taken_e high: flush_d=1, flush_e=1, stall_f=0, stall_d=0. The branch wins over ldr_stall in the same cycle.
REQ-009 Otherwise: stall_f = ldr_stall or pc_pend; stall_d = ldr_stall; flush_e = ldr_stall; flush_d = pc_pend or pcsrc_w.
REQ-010 Outside mem_stall, stall_e, stall_m and flush_w SHALL be 0.
REQ-011 All REQ-003 to REQ-010 outputs SHALL be combinational on the current inputs and state, with zero latency.
REQ-012 The FSM SHALL have states IDLE, WAIT and ERR:
- IDLE->WAIT when mem_access_m and not mem_ready.
- WAIT->IDLE when mem_ready.
- WAIT->ERR when wait_cnt==TIMEOUT-1 and not mem_ready.
- ERR SHALL be held until reset.
REQ-013 wait_cnt SHALL clear in IDLE and increment each cycle in WAIT. A request completing on the same edge as the timeout SHALL go to IDLE, not ERR.
REQ-014 mem_err SHALL be 1 exactly while in ERR.
REQ-015 stall_cnt SHALL increment on each edge where stall_f==1; flush_cnt SHALL increment on each edge where flush_e==1. Both SHALL saturate at 2^CNT_W-1. clr_cnt SHALL zero both and takes priority over increment.

Reset
REQ-016 reset low SHALL immediately force state=IDLE, wait_cnt=0, stall_cnt=0, flush_cnt=0 and mem_err=0. Combinational outputs SHALL then follow inputs per REQ-003 to REQ-010.
REQ-017 reset asserted in WAIT or ERR SHALL abort the wait. The first edge after reset release SHALL evaluate from IDLE.

Structure
REQ-018 A shared package SHALL hold the forward-select encoding enum (FWD_REG, FWD_RESW, FWD_ALUM) and the FSM state enum.
REQ-019 The saturating counter SHALL be one sub-module, sat_counter (parameter width; inputs clr and inc), instantiated twice.

Verification
REQ-020 Forwarding: reg_write_m=1, wa3m=3, reg_write_w=1, wa3w=3, ra1e=3 -> forward_ae=10. Then reg_write_m=0 -> 01. Then ra1e=15, wa3m=15 -> 00.
REQ-021 Load-use: mem_to_reg_e=1, wa3e=5, ra2d=5 -> stall_f=1, stall_d=1, flush_e=1. Add branch_taken_e=1 -> stall_f=0, flush_d=1, flush_e=1.
REQ-022 PC write: pcsrc_d pulses and walks through e, m and w over 4 cycles -> stall_f=1 for 3 cycles, flush_d=1 for 4 cycles; stall_cnt=3.
REQ-023 Memory wait: mem_access_m=1, mem_ready=0 for 5 cycles, then 1 -> all stalls and flush_w high for 5 cycles; state WAIT then IDLE; mem_err=0.
REQ-024 Timeout: TIMEOUT=4, mem_ready held 0 -> mem_err=1 after the 5th edge and stays 1. Asserting reset clears it.
REQ-025 Counters: CNT_W=2, stall_f held high for 6 edges -> stall_cnt=3. Pulse clr_cnt -> 0.
